// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared encodings for the multi-way intersection controller
package traffic_pkg;

    localparam logic [1:0] ST_GREEN  = 2'd0;
    localparam logic [1:0] ST_AMBER  = 2'd1;
    localparam logic [1:0] ST_ALLRED = 2'd2;
    localparam logic [1:0] ST_FLASH  = 2'd3;

    // Per-road lamp field is {R,A,G}
    localparam logic [2:0] LIGHT_R   = 3'b100;
    localparam logic [2:0] LIGHT_A   = 3'b010;
    localparam logic [2:0] LIGHT_G   = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    // Per-road pedestrian field is {WALK,DONT_WALK}
    localparam logic [1:0] PED_WALK      = 2'b10;
    localparam logic [1:0] PED_DONT_WALK = 2'b01;

    typedef enum logic [1:0] {
        PS_ADDR = 2'd0,
        PS_HI   = 2'd1,
        PS_LO   = 2'd2
    } prog_state_t;

    function automatic int next_index(input int cur, input int step, input int n);
        return (cur + step) % n;
    endfunction

endpackage

// File: rtl/traffic_multiway_controller_if.sv
// rtl/traffic_multiway_controller_if.sv - programming, request and lamp bundle of the controller
interface traffic_multiway_controller_if #(
    parameter int NUM_ROADS = 4,
    parameter int TW        = 7
);
    logic                   dav;
    logic [3:0]             dataIn;
    logic [NUM_ROADS-1:0]   ped_req;
    logic                   flash_mode;
    logic [3*NUM_ROADS-1:0] road_light;
    logic [2*NUM_ROADS-1:0] ped_light;
    logic [TW-1:0]          time_remaining;
    logic [1:0]             active_road;
    logic [1:0]             state_flag;
    logic [1:0]             prog_state;

    modport master (
        output dav, dataIn, ped_req, flash_mode,
        input  road_light, ped_light, time_remaining, active_road, state_flag, prog_state
    );

    modport slave (
        input  dav, dataIn, ped_req, flash_mode,
        output road_light, ped_light, time_remaining, active_road, state_flag, prog_state
    );
endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter measuring the length of one phase
module phase_timer #(
    parameter int TW      = 7,
    parameter int RST_VAL = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic [TW-1:0] count,
    output logic          done
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= TW'(RST_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Last second of the phase: the following clock moves on
    assign done = (count == TW'(1));
endmodule

// File: rtl/traffic_multiway_controller.sv
// rtl/traffic_multiway_controller.sv - round-robin N-road signal sequencer with programming and flash
module traffic_multiway_controller
    import traffic_pkg::*;
#(
    parameter int NUM_ROADS  = 4,
    parameter int TW         = 7,
    parameter int DEF_GREEN  = 20,
    parameter int DEF_AMBER  = 3,
    parameter int DEF_ALLRED = 2
) (
    input logic clock1Hz,
    input logic reset,
    traffic_multiway_controller_if.slave bus
);
    logic [1:0]             state_q;
    logic [1:0]             active_q;
    logic                   walk_q;
    logic                   toggle_q;
    logic [NUM_ROADS-1:0]   latch_q;
    logic [NUM_ROADS-1:0]   latch_clr;
    logic [NUM_ROADS-1:0]   green_nz;
    logic [TW-1:0]          green_q [NUM_ROADS];
    logic [TW-1:0]          amber_q;
    logic [TW-1:0]          allred_q;
    logic [TW-1:0]          amber_eff;
    logic [TW-1:0]          allred_eff;
    logic [TW-1:0]          sel_green;

    logic                   dav_d;
    logic                   dav_edge;
    prog_state_t            ps_q;
    logic [3:0]             addr_q;
    logic [3:0]             hi_q;
    logic [TW+7:0]          frame_val;
    logic [TW-1:0]          wr_val;
    logic                   unused_frame;

    logic                   tmr_load;
    logic [TW-1:0]          tmr_val;
    logic [TW-1:0]          tmr_count;
    logic                   tmr_done;

    logic                   nxt_found;
    logic [1:0]             nxt_road;
    logic                   nxt_walk;
    logic                   enter_green;
    logic [3*NUM_ROADS-1:0] road_light;
    logic [2*NUM_ROADS-1:0] ped_light;

    phase_timer #(.TW(TW), .RST_VAL(DEF_ALLRED)) u_timer (
        .clk      (clock1Hz),
        .rst_n    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    assign amber_eff  = (amber_q  == '0) ? TW'(1) : amber_q;
    assign allred_eff = (allred_q == '0) ? TW'(1) : allred_q;

    // Zero-extend so any TW works; the bits above TW are dropped by design
    assign frame_val    = {{TW{1'b0}}, hi_q, bus.dataIn};
    assign wr_val       = frame_val[TW-1:0];
    assign unused_frame = ^frame_val[TW+7:TW];
    assign dav_edge     = bus.dav & ~dav_d;

    always_ff @(posedge clock1Hz or negedge reset) begin
        if (!reset) begin
            dav_d    <= 1'b0;
            ps_q     <= PS_ADDR;
            addr_q   <= '0;
            hi_q     <= '0;
            amber_q  <= TW'(DEF_AMBER);
            allred_q <= TW'(DEF_ALLRED);
            for (int k = 0; k < NUM_ROADS; k++) green_q[k] <= TW'(DEF_GREEN);
        end else begin
            dav_d <= bus.dav;
            if (dav_edge) begin
                case (ps_q)
                    PS_ADDR: begin
                        if (bus.dataIn <= 4'(NUM_ROADS + 1)) begin
                            addr_q <= bus.dataIn;
                            ps_q   <= PS_HI;
                        end
                    end
                    PS_HI: begin
                        hi_q <= bus.dataIn;
                        ps_q <= PS_LO;
                    end
                    PS_LO: begin
                        ps_q <= PS_ADDR;
                        if (addr_q == 4'(NUM_ROADS)) begin
                            amber_q <= wr_val;
                        end else if (addr_q == 4'(NUM_ROADS + 1)) begin
                            allred_q <= wr_val;
                        end else begin
                            for (int k = 0; k < NUM_ROADS; k++)
                                if (addr_q == 4'(k)) green_q[k] <= wr_val;
                        end
                    end
                    default: ps_q <= PS_ADDR;
                endcase
            end
        end
    end

    always_comb begin
        green_nz = '0;
        for (int k = 0; k < NUM_ROADS; k++) green_nz[k] = (green_q[k] != '0);
    end

    // Walk the candidates from farthest to nearest so the nearest enabled road wins
    always_comb begin
        nxt_found = 1'b0;
        nxt_road  = '0;
        sel_green = allred_eff;
        nxt_walk  = 1'b0;
        for (int i = NUM_ROADS; i >= 1; i--) begin
            for (int k = 0; k < NUM_ROADS; k++) begin
                if (green_nz[k] && (k == next_index(int'(active_q), i, NUM_ROADS))) begin
                    nxt_found = 1'b1;
                    nxt_road  = 2'(k);
                    sel_green = green_q[k];
                    nxt_walk  = latch_q[k];
                end
            end
        end
    end

    assign enter_green = !bus.flash_mode && (state_q == ST_ALLRED) && tmr_done && nxt_found;

    always_comb begin
        latch_clr = '0;
        for (int k = 0; k < NUM_ROADS; k++) latch_clr[k] = enter_green && (nxt_road == 2'(k));
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = allred_eff;
        if (!bus.flash_mode) begin
            if (state_q == ST_FLASH) begin
                tmr_load = 1'b1;
            end else if (tmr_done) begin
                tmr_load = 1'b1;
                case (state_q)
                    ST_GREEN:  tmr_val = amber_eff;
                    ST_ALLRED: if (nxt_found) tmr_val = sel_green;
                    default:   tmr_val = allred_eff;
                endcase
            end
        end
    end

    always_ff @(posedge clock1Hz or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ALLRED;
            active_q <= 2'(NUM_ROADS - 1);
            walk_q   <= 1'b0;
            toggle_q <= 1'b1;
            latch_q  <= '0;
        end else begin
            // A request on the clearing clock re-arms the latch
            latch_q <= (latch_q & ~latch_clr) | bus.ped_req;
            if (bus.flash_mode) begin
                state_q  <= ST_FLASH;
                toggle_q <= (state_q == ST_FLASH) ? ~toggle_q : 1'b1;
            end else if (state_q == ST_FLASH) begin
                state_q <= ST_ALLRED;
            end else if (tmr_done) begin
                case (state_q)
                    ST_GREEN: state_q <= ST_AMBER;
                    ST_AMBER: state_q <= ST_ALLRED;
                    default: begin
                        if (nxt_found) begin
                            state_q  <= ST_GREEN;
                            active_q <= nxt_road;
                            walk_q   <= nxt_walk;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        road_light = '0;
        ped_light  = '0;
        for (int k = 0; k < NUM_ROADS; k++) begin
            road_light[3*k +: 3] = LIGHT_R;
            if (state_q == ST_FLASH) begin
                road_light[3*k +: 3] = toggle_q ? LIGHT_A : LIGHT_OFF;
            end else if (active_q == 2'(k)) begin
                if (state_q == ST_GREEN) road_light[3*k +: 3] = LIGHT_G;
                if (state_q == ST_AMBER) road_light[3*k +: 3] = LIGHT_A;
            end
            ped_light[2*k +: 2] = (state_q == ST_GREEN && walk_q && active_q == 2'(k))
                                  ? PED_WALK : PED_DONT_WALK;
        end
    end

    assign bus.road_light     = road_light;
    assign bus.ped_light      = ped_light;
    assign bus.time_remaining = (state_q == ST_FLASH) ? '0 : tmr_count;
    assign bus.active_road    = active_q;
    assign bus.state_flag     = state_q;
    assign bus.prog_state     = ps_q;
endmodule

// File: tb/tb_traffic_multiway_controller.sv
// tb/tb_traffic_multiway_controller.sv - self-checking bench for traffic_multiway_controller
module tb_traffic_multiway_controller;
    localparam int NR = 4;
    localparam int TW = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    traffic_multiway_controller_if #(.NUM_ROADS(NR), .TW(TW)) bus ();

    traffic_multiway_controller #(
        .NUM_ROADS(NR), .TW(TW), .DEF_GREEN(20), .DEF_AMBER(3), .DEF_ALLRED(2)
    ) dut (
        .clock1Hz (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    // Reference model: phase 0 green, 1 amber, 2 all-red, 3 flash
    int m_phase, m_rem, m_road, m_tog;
    bit m_walk;
    bit m_latch [NR];
    int m_green [NR];
    int m_amber, m_allred;
    int m_nib [$];
    bit m_dav_prev;

    typedef struct {
        bit             dav;
        int             din;
        logic [NR-1:0]  ped;
        bit             fl;
        int             st;
        int             tr;
        int             ar;
        int             ps;
        int             rl;
    } vec_t;
    vec_t vt [14];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic m_reset();
        m_phase = 2; m_rem = 2; m_road = NR - 1; m_tog = 1; m_walk = 0;
        for (int k = 0; k < NR; k++) begin m_latch[k] = 0; m_green[k] = 20; end
        m_amber = 3; m_allred = 2;
        m_nib.delete();
        m_dav_prev = 0;
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic m_step(input bit d, input int din, input logic [NR-1:0] pr, input bit fl);
        int clr;
        int found;
        int c;
        int v;
        clr = -1;
        found = -1;
        if (fl) begin
            m_tog = (m_phase == 3) ? 1 - m_tog : 1;
            m_phase = 3;
        end else if (m_phase == 3) begin
            m_phase = 2; m_rem = eff(m_allred);
        end else if (m_rem == 1) begin
            if (m_phase == 0) begin
                m_phase = 1; m_rem = eff(m_amber);
            end else if (m_phase == 1) begin
                m_phase = 2; m_rem = eff(m_allred);
            end else begin
                for (int i = 1; i <= NR; i++) begin
                    c = (m_road + i) % NR;
                    if (m_green[c] != 0) begin found = c; break; end
                end
                if (found >= 0) begin
                    m_phase = 0; m_road = found; m_rem = m_green[found];
                    m_walk = m_latch[found]; clr = found;
                end else begin
                    m_rem = eff(m_allred);
                end
            end
        end else begin
            m_rem--;
        end
        for (int k = 0; k < NR; k++) begin
            if (k == clr) m_latch[k] = 0;
            if (pr[k]) m_latch[k] = 1;
        end
        if (d && !m_dav_prev) begin
            if (!(m_nib.size() == 0 && din > NR + 1)) m_nib.push_back(din);
            if (m_nib.size() == 3) begin
                v = (m_nib[1] * 16 + m_nib[2]) % (1 << TW);
                if (m_nib[0] < NR) m_green[m_nib[0]] = v;
                else if (m_nib[0] == NR) m_amber = v;
                else m_allred = v;
                m_nib.delete();
            end
        end
        m_dav_prev = d;
    endtask

    function automatic logic [3*NR-1:0] m_rl();
        logic [3*NR-1:0] r;
        for (int k = 0; k < NR; k++) begin
            if (m_phase == 3) r[3*k +: 3] = m_tog ? 3'b010 : 3'b000;
            else if (m_phase == 0 && k == m_road) r[3*k +: 3] = 3'b001;
            else if (m_phase == 1 && k == m_road) r[3*k +: 3] = 3'b010;
            else r[3*k +: 3] = 3'b100;
        end
        return r;
    endfunction

    function automatic logic [2*NR-1:0] m_pl();
        logic [2*NR-1:0] r;
        for (int k = 0; k < NR; k++)
            r[2*k +: 2] = (m_phase == 0 && k == m_road && m_walk) ? 2'b10 : 2'b01;
        return r;
    endfunction

    task automatic check_model();
        chk("model_road_light", int'(bus.road_light), int'(m_rl()));
        chk("model_ped_light", int'(bus.ped_light), int'(m_pl()));
        chk("model_time_remaining", int'(bus.time_remaining), (m_phase == 3) ? 0 : m_rem);
        chk("model_active_road", int'(bus.active_road), m_road);
        chk("model_state_flag", int'(bus.state_flag), m_phase);
        chk("model_prog_state", int'(bus.prog_state), m_nib.size());
    endtask

    task automatic cycle(input bit d, input int din, input logic [NR-1:0] pr, input bit fl);
        bus.dav = d; bus.dataIn = 4'(din); bus.ped_req = pr; bus.flash_mode = fl;
        @(posedge clk);
        m_step(d, din, pr, fl);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle();
        cycle(1'b0, 0, '0, 1'b0);
    endtask

    task automatic send_frame(input int a, input int hi, input int lo);
        cycle(1'b1, a, '0, 1'b0);  cycle(1'b0, a, '0, 1'b0);
        cycle(1'b1, hi, '0, 1'b0); cycle(1'b0, hi, '0, 1'b0);
        cycle(1'b1, lo, '0, 1'b0); cycle(1'b0, lo, '0, 1'b0);
    endtask

    task automatic do_reset();
        bus.dav = 1'b0; bus.dataIn = '0; bus.ped_req = '0; bus.flash_mode = 1'b0;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_model();
    endtask

    task automatic measure_green(input int road, output int len);
        bit found;
        found = 0;
        len = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            idle();
            if (bus.state_flag == 2'd0 && int'(bus.active_road) == road) found = 1;
        end
        if (found) begin
            len = 1;
            for (int c = 0; c < 300; c++) begin
                idle();
                if (bus.state_flag == 2'd0 && int'(bus.active_road) == road) len++;
                else break;
            end
        end
    endtask

    initial begin
        int n;
        int w;
        int cnt;
        int prev;
        int seq [4];
        bit found;
        bit fl_s;
        bit d;
        int din;
        logic [NR-1:0] pr;

        vt[0]  = '{1'b1, 1, 4'b0000, 1'b0, 2,  1, 3, 1, 'h924};
        vt[1]  = '{1'b0, 0, 4'b0000, 1'b0, 0, 20, 0, 1, 'h921};
        vt[2]  = '{1'b1, 0, 4'b0000, 1'b0, 0, 19, 0, 2, 'h921};
        vt[3]  = '{1'b0, 0, 4'b0000, 1'b0, 0, 18, 0, 2, 'h921};
        vt[4]  = '{1'b1, 5, 4'b0000, 1'b0, 0, 17, 0, 0, 'h921};
        vt[5]  = '{1'b0, 0, 4'b0100, 1'b0, 0, 16, 0, 0, 'h921};
        vt[6]  = '{1'b1, 9, 4'b0000, 1'b0, 0, 15, 0, 0, 'h921};
        vt[7]  = '{1'b0, 0, 4'b0000, 1'b0, 0, 14, 0, 0, 'h921};
        vt[8]  = '{1'b0, 0, 4'b0000, 1'b1, 3,  0, 0, 0, 'h492};
        vt[9]  = '{1'b0, 0, 4'b0000, 1'b1, 3,  0, 0, 0, 'h000};
        vt[10] = '{1'b0, 0, 4'b0000, 1'b1, 3,  0, 0, 0, 'h492};
        vt[11] = '{1'b0, 0, 4'b0000, 1'b0, 2,  2, 0, 0, 'h924};
        vt[12] = '{1'b0, 0, 4'b0000, 1'b0, 2,  1, 0, 0, 'h924};
        vt[13] = '{1'b0, 0, 4'b0000, 1'b0, 0,  5, 1, 0, 'h90C};

        do_reset();
        chk("reset_state_flag", int'(bus.state_flag), 2);
        chk("reset_time_remaining", int'(bus.time_remaining), 2);
        chk("reset_active_road", int'(bus.active_road), 3);
        chk("reset_road_light", int'(bus.road_light), 'h924);
        chk("reset_ped_light", int'(bus.ped_light), 'h55);
        chk("reset_prog_state", int'(bus.prog_state), 0);

        for (int i = 0; i < 14; i++) begin
            cycle(vt[i].dav, vt[i].din, vt[i].ped, vt[i].fl);
            chk($sformatf("vec%0d_state_flag", i), int'(bus.state_flag), vt[i].st);
            chk($sformatf("vec%0d_time_remaining", i), int'(bus.time_remaining), vt[i].tr);
            chk($sformatf("vec%0d_active_road", i), int'(bus.active_road), vt[i].ar);
            chk($sformatf("vec%0d_prog_state", i), int'(bus.prog_state), vt[i].ps);
            chk($sformatf("vec%0d_road_light", i), int'(bus.road_light), vt[i].rl);
        end

        n = 1;
        for (int c = 0; c < 50; c++) begin
            idle();
            if (bus.state_flag == 2'd0 && bus.active_road == 2'd1) n++;
            else break;
        end
        chk("road1_green_len", n, 5);
        chk("road1_then_amber", int'(bus.state_flag), 1);

        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            idle();
            if (bus.state_flag == 2'd0 && bus.active_road == 2'd2) found = 1;
        end
        chk("reach_road2_green", int'(found), 1);
        w = (bus.ped_light == 8'h65) ? 1 : 0;
        for (int c = 0; c < 100; c++) begin
            idle();
            if (bus.state_flag == 2'd0 && bus.active_road == 2'd2) begin
                if (bus.ped_light == 8'h65) w++;
            end else break;
        end
        chk("ped2_walk_cycles", w, 20);
        chk("ped2_dont_walk_at_amber", int'(bus.ped_light), 'h55);

        send_frame(1, 0, 0);
        send_frame(3, 0, 0);
        send_frame(0, 0, 3);
        send_frame(2, 0, 4);
        cnt = 0;
        prev = int'(bus.state_flag);
        for (int c = 0; c < 400 && cnt < 4; c++) begin
            idle();
            if (bus.state_flag == 2'd0 && prev != 0) begin
                seq[cnt] = int'(bus.active_road);
                cnt++;
            end
            prev = int'(bus.state_flag);
        end
        chk("zero_skip_entries", cnt, 4);
        for (int i = 0; i < cnt; i++) begin
            chk("zero_skip_road_enabled", int'(seq[i] == 0 || seq[i] == 2), 1);
            if (i > 0) chk("zero_skip_alternates", int'(seq[i] != seq[i-1]), 1);
        end

        send_frame(0, 0, 0);
        send_frame(2, 0, 0);
        repeat (20) idle();
        for (int c = 0; c < 30; c++) begin
            idle();
            chk("all_zero_state", int'(bus.state_flag), 2);
            chk("all_zero_lights", int'(bus.road_light), 'h924);
        end

        do_reset();
        cycle(1'b1, 9, '0, 1'b0);
        cycle(1'b0, 9, '0, 1'b0);
        chk("invalid_addr_dropped", int'(bus.prog_state), 0);
        send_frame(1, 0, 7);
        chk("valid_frame_done", int'(bus.prog_state), 0);
        measure_green(1, n);
        chk("green1_programmed_len", n, 7);

        cycle(1'b1, 1, '0, 1'b0); cycle(1'b0, 1, '0, 1'b0);
        cycle(1'b1, 0, '0, 1'b0); cycle(1'b0, 0, '0, 1'b0);
        chk("partial_frame_prog_state", int'(bus.prog_state), 2);
        rst_n = 1'b0;
        #1;
        chk("midreset_prog_state", int'(bus.prog_state), 0);
        chk("midreset_state_flag", int'(bus.state_flag), 2);
        chk("midreset_road_light", int'(bus.road_light), 'h924);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_model();
        measure_green(1, n);
        chk("green1_default_after_reset", n, 20);

        fl_s = 0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 299) == 0) fl_s = ~fl_s;
            d   = ($urandom_range(0, 2) == 0);
            din = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 7));
            pr  = ($urandom_range(0, 9) == 0) ? NR'($urandom_range(0, 15)) : '0;
            cycle(d, din, pr, fl_s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
